// File: rtl/nios_ocm_pkg.sv
// rtl/nios_ocm_pkg.sv - shared types and helpers for the dual-port on-chip memory
//
// Contents:
//   ocm_state_t    clear-sweep FSM states (ST_CLEAR, ST_READY)
//   BE_W           byte-enable width for the default 32-bit data path
//   merge_lane()   per-byte winner when both ports write the same word
package nios_ocm_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ocm_state_t;

    localparam int DEFAULT_DATA_W = 32;
    localparam int BE_W           = DEFAULT_DATA_W / 8;

    // Same-word, same-cycle write: port 1 owns every lane it enables,
    // port 2 fills the lanes port 1 leaves alone.
    function automatic logic [7:0] merge_lane(
        input logic       s1_lane_en,
        input logic [7:0] s1_byte,
        input logic [7:0] s2_byte
    );
        return s1_lane_en ? s1_byte : s2_byte;
    endfunction

endpackage

// File: rtl/nios_ocm_port_ctrl.sv
// rtl/nios_ocm_port_ctrl.sv - one Avalon-MM slave port: acceptance, read pipeline, range masking
//
// Optional build macro: NIOS_OCM_OUTREG_EN adds a second output register
// stage (read latency 2 instead of 1, still one read per cycle).
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   clken            global clock enable; low stalls the port and freezes the pipeline
//   ready            memory initialised (clear sweep finished)
//   address          word address, may exceed DEPTH
//   chipselect, read, write  Avalon request qualifiers
//   mem_rdata        storage word currently addressed by this port
//   wr_en            accepted, in-range write this cycle
//   readdata         read result (0 for out-of-range addresses), holds between reads
//   readdatavalid    one-cycle pulse qualifying readdata
//   waitrequest      request not accepted while high
module nios_ocm_port_ctrl
    import nios_ocm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    input  logic              ready,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wr_en,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    output logic              waitrequest
);

    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic              in_range;
    logic              accept;
    logic              rd_acc;
    logic [DATA_W-1:0] rd_word;

    assign in_range    = ({1'b0, address} < DEPTH_L);
    assign waitrequest = ~ready | ~clken;
    assign accept      = chipselect & (read | write) & ~waitrequest & clken;
    // read+write together is a write: no read data is returned.
    assign rd_acc      = accept & read & ~write;
    assign wr_en       = accept & write & in_range;
    assign rd_word     = in_range ? mem_rdata : '0;

`ifdef NIOS_OCM_OUTREG_EN
    logic              stg_valid;
    logic [DATA_W-1:0] stg_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_valid     <= 1'b0;
            stg_data      <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else if (clken) begin
            stg_valid     <= rd_acc;
            if (rd_acc) begin
                stg_data <= rd_word;
            end
            readdatavalid <= stg_valid;
            if (stg_valid) begin
                readdata <= stg_data;
            end
        end else begin
            // First stage holds its pending word; the visible pulse is dropped
            // and re-issued on the next enabled cycle.
            readdatavalid <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            // rd_acc is already low whenever clken is low.
            readdatavalid <= rd_acc;
            if (rd_acc) begin
                readdata <= rd_word;
            end
        end
    end
`endif

endmodule

// File: rtl/nios_onchip_memory_dp.sv
// rtl/nios_onchip_memory_dp.sv - true dual-port on-chip RAM with clear-on-reset sweep
//
// Optional build macro: NIOS_OCM_OUTREG_EN (read latency 2, see nios_ocm_port_ctrl).
//
// Ports:
//   clk, reset   single clock, asynchronous active-high reset
//   clken        global clock enable; low freezes memory, FSM and port pipelines
//   init_done    high once the clear sweep has finished
//   s1_*, s2_*   two identical Avalon-MM slaves: address, chipselect, read, write,
//                byteenable, writedata in; readdata, readdatavalid, waitrequest out
module nios_onchip_memory_dp
    import nios_ocm_pkg::*;
#(
    parameter int                DATA_W         = 32,
    parameter int                DEPTH          = 2048,
    parameter int                ADDR_W         = 11,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    output logic                  init_done,

    input  logic [ADDR_W-1:0]     s1_address,
    input  logic                  s1_chipselect,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0]     s1_writedata,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,
    output logic                  s1_waitrequest,

    input  logic [ADDR_W-1:0]     s2_address,
    input  logic                  s2_chipselect,
    input  logic                  s2_read,
    input  logic                  s2_write,
    input  logic [DATA_W/8-1:0]   s2_byteenable,
    input  logic [DATA_W-1:0]     s2_writedata,
    output logic [DATA_W-1:0]     s2_readdata,
    output logic                  s2_readdatavalid,
    output logic                  s2_waitrequest
);

    localparam int                LANES       = DATA_W / 8;
    localparam int                IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam ocm_state_t        RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    localparam logic [ADDR_W-1:0] LAST_WORD   = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    ocm_state_t        state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              sweep_active;
    logic              sweep_we;

    logic              s1_wr_en, s2_wr_en;
    logic              collide;
    logic [IDX_W-1:0]  s1_idx, s2_idx, clr_idx;
    logic [DATA_W-1:0] s1_mem_rdata, s2_mem_rdata;

    // Index truncation can alias out-of-range addresses onto real words;
    // the port controllers suppress those writes and zero those reads.
    assign s1_idx  = IDX_W'(s1_address);
    assign s2_idx  = IDX_W'(s2_address);
    assign clr_idx = IDX_W'(clr_cnt);

    // Combinational read: a port reading the word the other port writes this
    // cycle sees the old contents; a word written last cycle is already updated.
    assign s1_mem_rdata = mem[s1_idx];
    assign s2_mem_rdata = mem[s2_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RESET_STATE;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else if (clken) begin
            state     <= state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            init_done <= (state_nxt == ST_READY);
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_cnt_nxt  = clr_cnt;
        sweep_active = 1'b0;
        case (state)
            ST_CLEAR: begin
                sweep_active = 1'b1;
                if (clr_cnt == LAST_WORD) begin
                    state_nxt   = ST_READY;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            ST_READY: begin
                sweep_active = 1'b0;
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

    assign sweep_we = sweep_active & clken & ~reset;
    assign collide  = s1_wr_en & s2_wr_en & (s1_address == s2_address);

    // Both ports are stalled during the sweep, so it never competes with them.
    // On a same-word collision only the port-1 path writes, carrying the merged word.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[clr_idx] <= CLEAR_VALUE;
        end else begin
            for (int b = 0; b < LANES; b++) begin
                if (s2_wr_en && !collide && s2_byteenable[b]) begin
                    mem[s2_idx][8*b +: 8] <= s2_writedata[8*b +: 8];
                end
                if (s1_wr_en && (s1_byteenable[b] || (collide && s2_byteenable[b]))) begin
                    mem[s1_idx][8*b +: 8] <= merge_lane(s1_byteenable[b],
                                                        s1_writedata[8*b +: 8],
                                                        s2_writedata[8*b +: 8]);
                end
            end
        end
    end

    nios_ocm_port_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_port1 (
        .clk           (clk),
        .reset         (reset),
        .clken         (clken),
        .ready         (init_done),
        .address       (s1_address),
        .chipselect    (s1_chipselect),
        .read          (s1_read),
        .write         (s1_write),
        .mem_rdata     (s1_mem_rdata),
        .wr_en         (s1_wr_en),
        .readdata      (s1_readdata),
        .readdatavalid (s1_readdatavalid),
        .waitrequest   (s1_waitrequest)
    );

    nios_ocm_port_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_port2 (
        .clk           (clk),
        .reset         (reset),
        .clken         (clken),
        .ready         (init_done),
        .address       (s2_address),
        .chipselect    (s2_chipselect),
        .read          (s2_read),
        .write         (s2_write),
        .mem_rdata     (s2_mem_rdata),
        .wr_en         (s2_wr_en),
        .readdata      (s2_readdata),
        .readdatavalid (s2_readdatavalid),
        .waitrequest   (s2_waitrequest)
    );

endmodule
